frame_uart_readback: RTL and testbench

Reads the stored image back out of the SPRAM frame store and transmits it over UART, the opposite direction of the UART-to-SPRAM image write path. On a start pulse it walks SPRAM addresses 0 to W*H-1, packs pairs of 12-bit RGB444 pixels into 3 bytes, and serialises each byte as 8N1 on `uart_txd`. The block sits beside the frame store and shares its SPRAM port through a grant signal; the host uses it to verify an uploaded picture.

---
 rtl/frame_uart_readback.sv | 254 +++++++++++++++++++++++++
 tb/tb_frame_uart_readback.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_readback.sv
// Streams the SPRAM frame store out over 8N1 UART, packing two RGB444 pixels into three bytes.
// Latency: first start bit 4 cycles after the start pulse with grant held; characters are gap-free.
// Backpressure: reads stall while spram_gnt is low; abort drains the current character, then idles.
module frame_uart_readback #(
  parameter int W            = 200,
  parameter int H            = 150,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        spram_gnt,
  output logic        spram_rd_en,
  output logic [14:0] spram_addr,
  input  logic [11:0] spram_rd_data,
  output logic        uart_txd,
  output logic        busy,
  output logic        done
);

  // W*H must not exceed 32768 so the pixel counter fits 16 bits and addresses fit 15 bits.
  localparam int              PIX_TOTAL = W * H;
  localparam logic [15:0]     PIX_END   = 16'(PIX_TOTAL);
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_WAIT0,
    S_FETCH1,
    S_WAIT1,
    S_SEND,
    S_FINISH
  } state_t;

  // Readback sequencer state
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] p0_q, p0_d;
  logic [11:0] p1_q, p1_d;
  logic [1:0]  k_q, k_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fetch_q, fetch_d;

  // Serializer state
  logic          tx_busy_q, tx_busy_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_clk_q, tx_clk_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  logic        ld;
  logic [7:0]  ld_byte;
  logic        ser_rdy;
  logic        abort_now;
  logic [15:0] cnt_inc;
  logic [23:0] pair;

  // The serializer can take a byte while idle or during the final clock of a stop
  // bit; loading on that last clock is what makes consecutive characters gap-free.
  assign ser_rdy   = !tx_busy_q || (tx_bit_q == 4'd9 && tx_clk_q == BIT_LAST);
  assign abort_now = abort | abort_q;
  assign cnt_inc   = cnt_q + 16'd1;
  assign pair      = {p0_q, p1_q};

  // Byte k of the current pair: the two pixels concatenated, taken MSB byte first.
  always_comb begin
    ld_byte = pair[7:0];
    case (k_q)
      2'd0:    ld_byte = pair[23:16];
      2'd1:    ld_byte = pair[15:8];
      default: ld_byte = pair[7:0];
    endcase
  end

  // Sequencer next-state: fetch a pixel pair, then feed its three bytes to the serializer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    k_d     = k_q;
    abort_d = abort_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld      = 1'b0;

    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
      if (start && !abort) begin
        state_d = S_FETCH0;
        cnt_d   = '0;
        addr_d  = '0;
        k_d     = '0;
        busy_d  = 1'b1;
      end
    end else begin
      if (abort) abort_d = 1'b1;
      if (abort_now) begin
        // No new reads or loads; leave once the character on the wire has finished.
        if (ser_rdy) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_FINISH;
        end
      end else begin
        case (state_q)
          S_FETCH0: begin
            if (spram_gnt) state_d = S_WAIT0;
          end
          S_WAIT0: begin
            p0_d    = spram_rd_data;
            cnt_d   = cnt_inc;
            if (cnt_inc < PIX_END) addr_d = cnt_inc[14:0];
            state_d = S_FETCH1;
          end
          S_FETCH1: begin
            // Odd pixel count: the last pair has no partner pixel, pad it with black.
            if (cnt_q == PIX_END) begin
              p1_d    = 12'h000;
              state_d = S_SEND;
            end else if (spram_gnt) begin
              state_d = S_WAIT1;
            end
          end
          S_WAIT1: begin
            p1_d    = spram_rd_data;
            cnt_d   = cnt_inc;
            if (cnt_inc < PIX_END) addr_d = cnt_inc[14:0];
            state_d = S_SEND;
            // b0 only needs p0, so start it now if the line is free.
            if (ser_rdy) begin
              ld  = 1'b1;
              k_d = 2'd1;
            end
          end
          S_SEND: begin
            if (ser_rdy) begin
              ld = 1'b1;
              if (k_q == 2'd2) begin
                k_d     = 2'd0;
                state_d = (cnt_q == PIX_END) ? S_FINISH : S_FETCH0;
              end else begin
                k_d = k_q + 2'd1;
              end
            end
          end
          S_FINISH: begin
            if (ser_rdy) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A fetch is pending whenever the next state is a FETCH that will really read.
  assign fetch_d = (state_d == S_FETCH0) || (state_d == S_FETCH1 && cnt_d != PIX_END);

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      k_q     <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      k_q     <= k_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fetch_q <= fetch_d;
    end
  end

  // Serializer next-state: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT long.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_bit_d  = tx_bit_q;
    tx_clk_d  = tx_clk_q;
    tx_sh_d   = tx_sh_q;
    txd_d     = txd_q;
    if (ld) begin
      tx_busy_d = 1'b1;
      tx_bit_d  = 4'd0;
      tx_clk_d  = '0;
      tx_sh_d   = {1'b1, ld_byte};
      txd_d     = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_clk_q == BIT_LAST) begin
        tx_clk_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          txd_d     = 1'b1;
        end else begin
          // The 1 shifted in on top becomes the stop bit after eight shifts.
          tx_bit_d = tx_bit_q + 4'd1;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
        end
      end else begin
        tx_clk_d = tx_clk_q + CW'(1);
      end
    end
  end

  // Serializer registers; reset drives the line to idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q <= 1'b0;
      tx_bit_q  <= '0;
      tx_clk_q  <= '0;
      tx_sh_q   <= '1;
      txd_q     <= 1'b1;
    end else begin
      tx_busy_q <= tx_busy_d;
      tx_bit_q  <= tx_bit_d;
      tx_clk_q  <= tx_clk_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
    end
  end

  // The grant is a same-cycle input, so the registered fetch request is qualified by it
  // here; this keeps the strobe from ever appearing in a cycle without the grant.
  assign spram_rd_en = fetch_q & spram_gnt;
  assign spram_addr  = addr_q;
  assign uart_txd    = txd_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_frame_uart_readback.sv
// Bench for frame_uart_readback: two instances (2-pixel and 3-pixel images) share stimulus.
// Each instance has an SPRAM model and a monitor that decodes UART characters and logs reads.
// Expected bytes are built by concatenating pixel pairs into 24-bit words and splitting them.
module tb_frame_uart_readback;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic gnt;
  logic clr_mon;
  int   cyc;
  int   n_chk;
  int   n_bad;
  logic [11:0] img [2][8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NP = (g == 0) ? 2 : 3;
    logic        txd, busy, done, rd_en;
    logic [14:0] addr;
    logic [11:0] rd_data;

    frame_uart_readback #(.W(NP), .H(1), .CLKS_PER_BIT(CPB)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .spram_gnt(gnt),
      .spram_rd_en(rd_en), .spram_addr(addr), .spram_rd_data(rd_data),
      .uart_txd(txd), .busy(busy), .done(done)
    );

    always @(posedge clk) if (rd_en) rd_data <= img[g][addr[2:0]];

    byte unsigned rx_q[$];
    int           rx_t[$];
    int           rd_q[$];
    int           rd_t[$];
    int           done_n, busy_fall, bad_frame, bad_rd, bad_done, bit_cnt;
    logic         in_char, busy_prev;
    logic [9:0]   sh;

    initial begin
      in_char = 0; busy_prev = 0; bit_cnt = 0; sh = '0;
      done_n = 0; busy_fall = -1; bad_frame = 0; bad_rd = 0; bad_done = 0;
      forever begin
        @(negedge clk);
        if (clr_mon) begin
          rx_q.delete(); rx_t.delete(); rd_q.delete(); rd_t.delete();
          done_n = 0; busy_fall = -1; bad_frame = 0; bad_rd = 0; bad_done = 0;
          in_char = 0; busy_prev = busy;
        end else if (!rst_n) begin
          in_char = 0; busy_prev = 0;
        end else begin
          if (rd_en) begin
            rd_q.push_back(int'(addr)); rd_t.push_back(cyc);
            if (!gnt || int'(addr) >= NP) bad_rd++;
          end
          if (done) done_n++;
          if (done && busy) bad_done++;
          if (busy_prev && !busy) busy_fall = cyc;
          busy_prev = busy;
          if (!in_char) begin
            if (!txd) begin in_char = 1; bit_cnt = 0; rx_t.push_back(cyc); end
          end else bit_cnt++;
          if (in_char) begin
            if (bit_cnt % CPB == CPB / 2) sh[bit_cnt / CPB] = txd;
            if (bit_cnt == 10 * CPB - 1) begin
              in_char = 0;
              if (sh[0] != 1'b0 || sh[9] != 1'b1) bad_frame++;
              rx_q.push_back(sh[8:1]);
            end
          end
        end
      end
    end
  end

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1; step(); clr_mon = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_txd0"}, g_dut[0].txd, 1);  chk_eq({tag, "_txd1"}, g_dut[1].txd, 1);
    chk_eq({tag, "_busy0"}, g_dut[0].busy, 0); chk_eq({tag, "_busy1"}, g_dut[1].busy, 0);
    chk_eq({tag, "_done0"}, g_dut[0].done, 0); chk_eq({tag, "_done1"}, g_dut[1].done, 0);
    chk_eq({tag, "_rden0"}, g_dut[0].rd_en, 0); chk_eq({tag, "_rden1"}, g_dut[1].rd_en, 0);
    chk_eq({tag, "_addr0"}, g_dut[0].addr, 0); chk_eq({tag, "_addr1"}, g_dut[1].addr, 0);
  endtask

  task automatic do_start(input string tag, output int st);
    start = 1'b1; step(); start = 1'b0;
    st = cyc;
    chk_eq({tag, "_busy_t1_0"}, g_dut[0].busy, 1);
    chk_eq({tag, "_busy_t1_1"}, g_dut[1].busy, 1);
  endtask

  task automatic wait_idle(input string tag, input bit rnd_gnt);
    int n = 0;
    while ((g_dut[0].busy || g_dut[1].busy) && n < 3000) begin
      if (rnd_gnt) gnt = 1'($urandom_range(0, 1));
      step(); n++;
    end
    gnt = 1'b1;
    chk_eq({tag, "_idle_in_time"}, (n < 3000), 1);
    step(); step();
  endtask

  task automatic rand_img();
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 8; i++) img[g][i] = 12'($urandom);
  endtask

  task automatic check_dut(input string tag, input int g, input int nb, input int nr,
                           input int exp_done, input bit gapfree, input int rd0_exp);
    byte unsigned got[$], exp[$];
    int t[$], rd[$], rdt[$];
    int dn, bf, bfr, brd, bdn, np;
    logic [23:0] w;
    string s;
    if (g == 0) begin
      got = g_dut[0].rx_q; t = g_dut[0].rx_t; rd = g_dut[0].rd_q; rdt = g_dut[0].rd_t;
      dn = g_dut[0].done_n; bf = g_dut[0].busy_fall; bfr = g_dut[0].bad_frame;
      brd = g_dut[0].bad_rd; bdn = g_dut[0].bad_done; np = 2;
    end else begin
      got = g_dut[1].rx_q; t = g_dut[1].rx_t; rd = g_dut[1].rd_q; rdt = g_dut[1].rd_t;
      dn = g_dut[1].done_n; bf = g_dut[1].busy_fall; bfr = g_dut[1].bad_frame;
      brd = g_dut[1].bad_rd; bdn = g_dut[1].bad_done; np = 3;
    end
    for (int i = 0; i < np; i += 2) begin
      w = {img[g][i], (i + 1 < np) ? img[g][i + 1] : 12'h000};
      exp.push_back(w[23:16]); exp.push_back(w[15:8]); exp.push_back(w[7:0]);
    end
    s = $sformatf("%s_d%0d", tag, g);
    chk_eq({s, "_nbytes"}, got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++)
      chk_eq($sformatf("%s_byte%0d", s, i), got[i], exp[i]);
    chk_eq({s, "_nreads"}, rd.size(), nr);
    for (int i = 0; i < nr && i < rd.size(); i++)
      chk_eq($sformatf("%s_rdaddr%0d", s, i), rd[i], i);
    chk_eq({s, "_done_cnt"}, dn, exp_done);
    chk_eq({s, "_frame_err"}, bfr, 0);
    chk_eq({s, "_bad_read"}, brd, 0);
    chk_eq({s, "_done_while_busy"}, bdn, 0);
    if (t.size() > 0) chk_eq({s, "_busy_fall"}, bf, t[t.size() - 1] + 10 * CPB);
    if (gapfree)
      for (int i = 1; i < t.size(); i++)
        chk_eq($sformatf("%s_gap%0d", s, i), t[i] - t[i - 1], 10 * CPB);
    if (rd0_exp >= 0 && t.size() > 0 && rdt.size() > 0) begin
      chk_eq({s, "_first_rd_cyc"}, rdt[0], rd0_exp);
      chk_eq({s, "_startbit_lat_ok"}, (t[0] - rd0_exp <= 4), 1);
    end
  endtask

  initial begin
    int st, gc, err, n;
    n_chk = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b1; clr_mon = 1'b0;
    img[0][0] = 12'hABC; img[0][1] = 12'h123;
    img[1][0] = 12'hFFF; img[1][1] = 12'h000; img[1][2] = 12'h5A5;
    repeat (3) step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();

    // Directed images, with a second start pulse mid-readback that must be ignored.
    clear_mon();
    do_start("dir", st);
    repeat (60) step();
    start = 1'b1; step(); start = 1'b0;
    wait_idle("dir", 0);
    check_dut("dir", 0, 3, 2, 1, 1, st);
    check_dut("dir", 1, 6, 3, 1, 1, st);

    // Grant withheld for 20 cycles after start.
    rand_img();
    clear_mon();
    gnt = 1'b0;
    do_start("stall", st);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      if (g_dut[0].rd_en || g_dut[1].rd_en || !g_dut[0].txd || !g_dut[1].txd) err++;
      step();
    end
    chk_eq("stall_quiet", err, 0);
    gnt = 1'b1; gc = cyc;
    wait_idle("stall", 0);
    check_dut("stall", 0, 3, 2, 1, 1, gc);
    check_dut("stall", 1, 6, 3, 1, 1, gc);

    // Randomly toggling grant over several random images.
    for (int r = 0; r < 3; r++) begin
      rand_img();
      clear_mon();
      do_start("rgnt", st);
      wait_idle("rgnt", 1);
      check_dut($sformatf("rgnt%0d", r), 0, 3, 2, 1, 0, -1);
      check_dut($sformatf("rgnt%0d", r), 1, 6, 3, 1, 0, -1);
    end

    // Abort during the 4th data bit of b1.
    rand_img();
    clear_mon();
    do_start("abort", st);
    n = 0;
    while (g_dut[1].rx_q.size() < 1 && n < 200) begin step(); n++; end
    chk_eq("abort_b0_seen", (n < 200), 1);
    repeat (17) step();
    abort = 1'b1;
    wait_idle("abort", 0);
    abort = 1'b0;
    step();
    check_dut("abort", 0, 2, 2, 0, 1, st);
    check_dut("abort", 1, 2, 2, 0, 1, st);

    // Start together with abort in IDLE: abort wins.
    clear_mon();
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    repeat (5) step();
    chk_eq("sa_busy0", g_dut[0].busy, 0);
    chk_eq("sa_busy1", g_dut[1].busy, 0);
    chk_eq("sa_reads", g_dut[0].rd_q.size() + g_dut[1].rd_q.size(), 0);

    // Asynchronous reset during the first start bit, then a full replay.
    rand_img();
    clear_mon();
    do_start("rst", st);
    n = 0;
    while (g_dut[0].txd && n < 20) begin step(); n++; end
    chk_eq("rst_startbit_seen", (n < 20), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    clear_mon();
    do_start("replay", st);
    wait_idle("replay", 0);
    check_dut("replay", 0, 3, 2, 1, 1, st);
    check_dut("replay", 1, 6, 3, 1, 1, st);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
